// File: rtl/rv32v_hazard_pkg.sv
// rv32v_hazard_pkg
// Shared types and defaults for the RV32V vector issue/hazard path.
// Holds the issue-controller state encoding and default sizing for the
// element count and the retire watchdog.
package rv32v_hazard_pkg;

    localparam int VLMAX_DEF   = 32;
    localparam int TIMEOUT_DEF = 1024;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DRAIN = 3'd1,
        ST_BUSY  = 3'd2,
        ST_DONE  = 3'd3,
        ST_FLUSH = 3'd4
    } vissue_state_t;

endpackage

// File: rtl/rv32v_vector_issue_ctrl_if.sv
// rv32v_vector_issue_ctrl_if
// Bundle between decode/ROB/hazard unit and the vector issue controller.
//   master : drives v_start, v_vl, v_is_cfg, elem_retire, exception_v,
//            busy_ex, busy_mem; observes the controller outputs.
//   slave  : the controller; drives v_busy, v_done, v_decode_done,
//            stall_front, flush_front, csr_update, v_timeout,
//            elem_remaining.
interface rv32v_vector_issue_ctrl_if
    import rv32v_hazard_pkg::*;
#(
    parameter int VL_W = $clog2(VLMAX_DEF) + 1
);
    logic            v_start;
    logic [VL_W-1:0] v_vl;
    logic            v_is_cfg;
    logic            elem_retire;
    logic            exception_v;
    logic            busy_ex;
    logic            busy_mem;

    logic            v_busy;
    logic            v_done;
    logic            v_decode_done;
    logic            stall_front;
    logic            flush_front;
    logic            csr_update;
    logic            v_timeout;
    logic [VL_W-1:0] elem_remaining;

    modport master (
        output v_start, v_vl, v_is_cfg, elem_retire, exception_v, busy_ex, busy_mem,
        input  v_busy, v_done, v_decode_done, stall_front, flush_front,
               csr_update, v_timeout, elem_remaining
    );

    modport slave (
        input  v_start, v_vl, v_is_cfg, elem_retire, exception_v, busy_ex, busy_mem,
        output v_busy, v_done, v_decode_done, stall_front, flush_front,
               csr_update, v_timeout, elem_remaining
    );

endinterface

// File: rtl/rv32v_retire_counter.sv
// rv32v_retire_counter
// Down-counter of vector elements still to retire.
//   clk, rst  : clock, async active-high reset
//   load      : load load_val
//   dec       : decrement by one, saturating at 0
//   clear     : force to 0 (highest priority)
//   count     : current value
//   zero      : count == 0
module rv32v_retire_counter #(
    parameter int VL_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            dec,
    input  logic            clear,
    input  logic [VL_W-1:0] load_val,
    output logic [VL_W-1:0] count,
    output logic            zero
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && count != '0) begin
            count <= count - VL_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/rv32v_vector_issue_ctrl.sv
// rv32v_vector_issue_ctrl
// Holds a vector instruction in decode, waits for the scalar EX/MEM stages
// to drain, tracks element retirement and raises front-end stall/flush.
// Serializes vsetvl (csr_update on completion) and aborts hung operations
// through a retire watchdog with a sticky v_timeout flag.
//   clk, rst : clock, async active-high reset
//   bus      : slave side of rv32v_vector_issue_ctrl_if
module rv32v_vector_issue_ctrl
    import rv32v_hazard_pkg::*;
#(
    parameter int VLMAX   = VLMAX_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input logic                        clk,
    input logic                        rst,
    rv32v_vector_issue_ctrl_if.slave   bus
);

    localparam int VL_W = $clog2(VLMAX) + 1;
    localparam int TO_W = $clog2(TIMEOUT);

    vissue_state_t   state;
    vissue_state_t   state_nxt;
    logic            cfg_q;
    logic [TO_W-1:0] wd;
    logic [TO_W-1:0] wd_inc;
    logic            wd_expire;
    logic            cnt_load;
    logic            cnt_dec;
    logic            cnt_clear;
    logic            cnt_zero;
    logic [VL_W-1:0] elem_cnt;

    rv32v_retire_counter #(.VL_W(VL_W)) u_retire_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .clear    (cnt_clear),
        .load_val (bus.v_vl),
        .count    (elem_cnt),
        .zero     (cnt_zero)
    );

    // The watchdog fires in the cycle it would reach TIMEOUT-1, so the
    // abort lands after TIMEOUT-1 consecutive retire-free BUSY cycles.
    assign wd_inc    = wd + TO_W'(1);
    assign wd_expire = (state == ST_BUSY) && !bus.elem_retire && (wd_inc == TO_W'(TIMEOUT - 1));

    // Exceptions win over everything else; entering FLUSH clears the
    // element count so it already reads 0 during the flush cycle.
    always_comb begin
        state_nxt = state;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        cnt_clear = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.v_start && bus.exception_v) begin
                    state_nxt = ST_FLUSH;
                    cnt_clear = 1'b1;
                end else if (bus.v_start) begin
                    state_nxt = ST_DRAIN;
                    cnt_load  = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (bus.exception_v) begin
                    state_nxt = ST_FLUSH;
                    cnt_clear = 1'b1;
                end else if (!bus.busy_ex && !bus.busy_mem) begin
                    state_nxt = cnt_zero ? ST_DONE : ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (bus.exception_v || wd_expire) begin
                    state_nxt = ST_FLUSH;
                    cnt_clear = 1'b1;
                end else if (bus.elem_retire) begin
                    cnt_dec = 1'b1;
                    if (elem_cnt == VL_W'(1)) begin
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE:  state_nxt = ST_IDLE;
            ST_FLUSH: state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The cfg bit travels with the instruction and is dropped on abort.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_q <= 1'b0;
        end else if (cnt_load) begin
            cfg_q <= bus.v_is_cfg;
        end else if (cnt_clear) begin
            cfg_q <= 1'b0;
        end
    end

    // Watchdog counts only retire-free BUSY cycles and restarts on any retire.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd <= '0;
        end else if (state != ST_BUSY || bus.elem_retire || bus.exception_v || wd_expire) begin
            wd <= '0;
        end else begin
            wd <= wd_inc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.v_timeout <= 1'b0;
        end else if (wd_expire) begin
            bus.v_timeout <= 1'b1;
        end
    end

    // stall_front is Mealy in IDLE so decode holds the instruction in the
    // very cycle it presents v_start; gated by rst so reset shows all zeros.
    assign bus.v_busy         = (state == ST_DRAIN) || (state == ST_BUSY);
    assign bus.stall_front    = !rst && (((state == ST_IDLE) && bus.v_start && !bus.exception_v)
                                         || bus.v_busy);
    assign bus.v_done         = (state == ST_DONE);
    assign bus.v_decode_done  = (state == ST_DONE);
    assign bus.csr_update     = (state == ST_DONE) && cfg_q;
    assign bus.flush_front    = (state == ST_FLUSH);
    assign bus.elem_remaining = elem_cnt;

endmodule

// File: tb/tb_rv32v_vector_issue_ctrl.sv
// tb_rv32v_vector_issue_ctrl
// Randomized and directed bench for rv32v_vector_issue_ctrl with a
// behavioural model of instruction progress compared on every cycle.
module tb_rv32v_vector_issue_ctrl;

    localparam int VLMAX   = 32;
    localparam int TIMEOUT = 16;
    localparam int VL_W    = $clog2(VLMAX) + 1;
    localparam int OBS_N   = 24;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    rv32v_vector_issue_ctrl_if #(.VL_W(VL_W)) bus ();

    rv32v_vector_issue_ctrl #(.VLMAX(VLMAX), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: an instruction is either absent, waiting for the
    // scalar stages, or retiring elements; completion and abort each show
    // as a one-cycle pulse during which nothing new is accepted.
    bit m_active;
    bit m_exec;
    int m_rem;
    int m_quiet;
    bit m_cfg;
    bit m_done;
    bit m_flush;
    bit m_to;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        bit nd;
        bit nf;
        if (rst) begin
            m_active = 0; m_exec = 0; m_rem = 0; m_quiet = 0;
            m_cfg = 0; m_done = 0; m_flush = 0; m_to = 0;
            check_output("rst_v_busy", 32'(bus.v_busy), 0);
            check_output("rst_stall", 32'(bus.stall_front), 0);
            check_output("rst_flush", 32'(bus.flush_front), 0);
            check_output("rst_done", 32'(bus.v_done), 0);
            check_output("rst_decdone", 32'(bus.v_decode_done), 0);
            check_output("rst_csr", 32'(bus.csr_update), 0);
            check_output("rst_timeout", 32'(bus.v_timeout), 0);
            check_output("rst_elem", 32'(bus.elem_remaining), 0);
        end else begin
            check_output("v_busy", 32'(bus.v_busy), 32'(m_active));
            check_output("v_done", 32'(bus.v_done), 32'(m_done));
            check_output("v_decode_done", 32'(bus.v_decode_done), 32'(m_done));
            check_output("csr_update", 32'(bus.csr_update), 32'(m_done && m_cfg));
            check_output("flush_front", 32'(bus.flush_front), 32'(m_flush));
            check_output("stall_front", 32'(bus.stall_front),
                         32'(m_active || (!m_done && !m_flush && bus.v_start && !bus.exception_v)));
            check_output("elem_remaining", 32'(bus.elem_remaining), 32'(m_rem));
            check_output("v_timeout", 32'(bus.v_timeout), 32'(m_to));

            nd = 0;
            nf = 0;
            if (m_done || m_flush) begin
                // turnaround cycle: nothing accepted
            end else if (!m_active) begin
                if (bus.v_start && bus.exception_v) begin
                    nf = 1; m_rem = 0; m_cfg = 0;
                end else if (bus.v_start) begin
                    m_active = 1; m_exec = 0; m_rem = int'(bus.v_vl); m_cfg = bus.v_is_cfg;
                end
            end else if (bus.exception_v) begin
                nf = 1; m_active = 0; m_rem = 0; m_cfg = 0;
            end else if (!m_exec) begin
                if (!bus.busy_ex && !bus.busy_mem) begin
                    if (m_rem == 0) begin
                        m_active = 0; nd = 1;
                    end else begin
                        m_exec = 1; m_quiet = 0;
                    end
                end
            end else if (bus.elem_retire) begin
                m_quiet = 0;
                m_rem = m_rem - 1;
                if (m_rem == 0) begin
                    m_active = 0; nd = 1;
                end
            end else begin
                m_quiet++;
                if (m_quiet == TIMEOUT - 1) begin
                    m_to = 1; nf = 1; m_active = 0; m_rem = 0; m_cfg = 0;
                end
            end
            m_done  = nd;
            m_flush = nf;
        end
    end

    // Per-scenario observation record, indexed by cycles since v_start.
    logic       obs_busy   [OBS_N];
    logic       obs_stall  [OBS_N];
    logic       obs_done   [OBS_N];
    logic       obs_dec    [OBS_N];
    logic       obs_csr    [OBS_N];
    logic       obs_flush  [OBS_N];
    logic       obs_to     [OBS_N];
    int         obs_elem   [OBS_N];

    task automatic apply_stimulus(input bit start, input int vl, input bit cfg, input bit ret,
                                  input bit exc, input bit bex, input bit bmem);
        bus.v_start     = start;
        bus.v_vl        = VL_W'(vl);
        bus.v_is_cfg    = cfg;
        bus.elem_retire = ret;
        bus.exception_v = exc;
        bus.busy_ex     = bex;
        bus.busy_mem    = bmem;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one instruction at k=0 and record OBS_N cycles. busy_mem is
    // high for k < bmem_n, exception_v pulses at k == exc_at.
    task automatic observe(input int vl, input bit cfg, input bit ret, input int bmem_n, input int exc_at);
        for (int k = 0; k < OBS_N; k++) begin
            apply_stimulus(k == 0, vl, cfg, ret, k == exc_at, 1'b0, k < bmem_n);
            @(negedge clk);
            obs_busy[k]  = bus.v_busy;
            obs_stall[k] = bus.stall_front;
            obs_done[k]  = bus.v_done;
            obs_dec[k]   = bus.v_decode_done;
            obs_csr[k]   = bus.csr_update;
            obs_flush[k] = bus.flush_front;
            obs_to[k]    = bus.v_timeout;
            obs_elem[k]  = int'(bus.elem_remaining);
            tick();
        end
        apply_stimulus(0, 0, 0, 0, 0, 0, 0);
    endtask

    function automatic int first_of(input logic v [OBS_N]);
        for (int k = 0; k < OBS_N; k++) if (v[k] === 1'b1) return k;
        return -1;
    endfunction

    function automatic int count_of(input logic v [OBS_N]);
        int n = 0;
        for (int k = 0; k < OBS_N; k++) if (v[k] === 1'b1) n++;
        return n;
    endfunction

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got running expected finished");
        $fatal(1, "[TB] simulation time limit");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        apply_stimulus(1, 5, 1, 1, 0, 0, 0);
        repeat (3) @(negedge clk);
        check_output("reset_hold_stall", 32'(bus.stall_front), 0);
        check_output("reset_hold_busy", 32'(bus.v_busy), 0);
        tick();
        rst = 1'b0;
        apply_stimulus(0, 0, 0, 0, 0, 0, 0);
        tick();

        $display("[TB] vl=4 back-to-back retires");
        observe(4, 0, 1, 0, -1);
        check_output("vl4_done_cycle", 32'(first_of(obs_done)), 6);
        check_output("vl4_done_count", 32'(count_of(obs_done)), 1);
        for (int k = 2; k <= 6; k++) check_output("vl4_elem_step", 32'(obs_elem[k]), 32'(6 - k));

        $display("[TB] vl=3 with busy_mem for 5 cycles");
        observe(3, 0, 1, 5, -1);
        check_output("drain_busy_cycles", 32'(count_of(obs_busy)), 8);
        check_output("drain_stall_cycles", 32'(count_of(obs_stall)), 9);
        check_output("drain_stall_at_start", 32'(obs_stall[0]), 1);
        check_output("drain_done_cycle", 32'(first_of(obs_done)), 9);

        $display("[TB] vsetvli vl=0");
        observe(0, 1, 0, 0, -1);
        check_output("cfg_done_cycle", 32'(first_of(obs_done)), 2);
        check_output("cfg_decdone_cycle", 32'(first_of(obs_dec)), 2);
        check_output("cfg_csr_cycle", 32'(first_of(obs_csr)), 2);
        check_output("cfg_csr_count", 32'(count_of(obs_csr)), 1);
        check_output("cfg_busy_cycles", 32'(count_of(obs_busy)), 1);

        $display("[TB] vl=8 exception on third retire");
        observe(8, 1, 1, 0, 4);
        check_output("exc_elem_before", 32'(obs_elem[4]), 6);
        check_output("exc_flush_cycle", 32'(first_of(obs_flush)), 5);
        check_output("exc_flush_count", 32'(count_of(obs_flush)), 1);
        check_output("exc_elem_in_flush", 32'(obs_elem[5]), 0);
        check_output("exc_no_done", 32'(count_of(obs_done)), 0);
        check_output("exc_no_csr", 32'(count_of(obs_csr)), 0);

        $display("[TB] watchdog with no retires");
        observe(2, 0, 0, 0, -1);
        check_output("wd_timeout_cycle", 32'(first_of(obs_to)), 17);
        check_output("wd_flush_cycle", 32'(first_of(obs_flush)), 17);
        check_output("wd_busy_cycles", 32'(count_of(obs_busy)), 16);
        observe(1, 0, 1, 0, -1);
        check_output("wd_sticky_done", 32'(first_of(obs_done)), 3);
        check_output("wd_sticky_flag", 32'(count_of(obs_to)), OBS_N);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 3000; i++) begin
            int vl;
            vl = ($urandom_range(0, 15) == 0) ? VLMAX : int'($urandom_range(0, 6));
            apply_stimulus($urandom_range(0, 3) == 0, vl, 1'($urandom_range(0, 1)),
                           $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0,
                           $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0);
            tick();
        end

        $display("[TB] reset mid-operation");
        apply_stimulus(0, 0, 0, 0, 0, 0, 0);
        repeat (4) tick();
        apply_stimulus(1, 10, 1, 1, 0, 0, 0);
        tick();
        apply_stimulus(0, 0, 0, 1, 0, 0, 0);
        repeat (4) tick();
        rst = 1'b1;
        #1;
        check_output("midrst_busy", 32'(bus.v_busy), 0);
        check_output("midrst_elem", 32'(bus.elem_remaining), 0);
        repeat (2) tick();
        rst = 1'b0;
        observe(3, 0, 1, 0, -1);
        check_output("post_rst_done_cycle", 32'(first_of(obs_done)), 5);
        check_output("post_rst_timeout", 32'(count_of(obs_to)), 0);

        for (int i = 0; i < 1500; i++) begin
            apply_stimulus($urandom_range(0, 2) == 0, int'($urandom_range(0, VLMAX)),
                           1'($urandom_range(0, 1)), $urandom_range(0, 4) != 0,
                           $urandom_range(0, 59) == 0, $urandom_range(0, 4) == 0,
                           $urandom_range(0, 4) == 0);
            tick();
        end

        apply_stimulus(0, 0, 0, 0, 0, 0, 0);
        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rv32v_vector_issue_ctrl.md
# rv32v_vector_issue_ctrl

Sequencing controller for the RV32V pipeline hazard path. It holds a vector instruction in decode, drains the scalar execute/memory stages, and tracks element retirement from the ROB. It produces the vector busy latch and the front-end stall/flush requests that the hazard unit merges into its per-stage controls. It also serializes vector configuration (vsetvl) instructions and recovers from hung vector operations through a watchdog.

## Interface
Parameters:
- VLMAX, 32: maximum elements per instruction; VL_W = $clog2(VLMAX)+1.
- TIMEOUT, 1024: cycles without an element retire before abort; TO_W = $clog2(TIMEOUT).

Ports:
- CLK  in  1  single clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- v_start  in  1  decode holds a valid vector instruction (already qualified by decode_ena).
- v_vl  in  VL_W  element count of that instruction; sampled with v_start; legal range 0..VLMAX.
- v_is_cfg  in  1  the instruction is vsetvl/vsetvli (updates vector CSRs).
- elem_retire  in  1  ROB retired one element this cycle.
- exception_v  in  1  vector exception; aborts the current instruction.
- busy_ex, busy_mem  in  1  scalar execute/memory occupancy.
- v_busy  out  1  vector stall latch.
- v_done  out  1  one-cycle completion pulse.
- v_decode_done  out  1  one-cycle pulse; decode may release the instruction.
- stall_front  out  1  stall f1, f2 and decode.
- flush_front  out  1  flush f1, f2 and decode.
- csr_update  out  1  one-cycle pulse when a cfg instruction completes.
- v_timeout  out  1  sticky watchdog flag; cleared only by RST.
- elem_remaining  out  VL_W  live count of elements not yet retired.

## Operation
FSM states are IDLE, DRAIN, BUSY, DONE and FLUSH.
- IDLE:
  - exception_v takes priority over v_start; if both are high, go to FLUSH.
  - On v_start, load elem_remaining with v_vl and latch v_is_cfg, then go to DRAIN.
- DRAIN: wait until busy_ex and busy_mem are both 0.
  - If the loaded count is 0, go to DONE.
  - Otherwise go to BUSY.
- BUSY:
  - Each elem_retire decrements elem_remaining.
  - A retire while elem_remaining==1 goes to DONE.
  - A watchdog counter resets on every retire and increments otherwise. When it reaches TIMEOUT-1 without a retire, set v_timeout and go to FLUSH.
- DONE: lasts one cycle.
  - Assert v_done and v_decode_done.
  - Assert csr_update if the latched cfg bit is set.
  - Go to IDLE.
- FLUSH: lasts one cycle.
  - Assert flush_front.
  - Clear elem_remaining and the cfg latch.
  - Go to IDLE.
- exception_v in DRAIN or BUSY goes to FLUSH and overrides any retire in the same cycle.
- elem_retire outside BUSY is ignored. The counter never decrements below 0.
- stall_front = (state==IDLE && v_start && !exception_v) || state==DRAIN || state==BUSY. This term is Mealy in IDLE, so the instruction holds in decode in its v_start cycle.
- v_busy = (state==DRAIN || state==BUSY), registered from the state.
- A v_start that arrives in any state other than IDLE is ignored.

## Timing
- Reset values: state IDLE, elem_remaining 0, watchdog 0, v_timeout 0, cfg latch 0. All pulse outputs are 0, and v_busy and stall_front are 0.
- v_start at cycle N (no drain needed, vl=k>0):
  - DRAIN at N+1, BUSY at N+2.
  - With one retire per cycle from N+2, the k-th retire is at N+k+1, DONE is at N+k+2, and IDLE is at N+k+3.
- vl=0: DONE at N+2, with one DRAIN cycle.
- Each additional cycle with busy_ex or busy_mem high extends DRAIN by one cycle.
- A new v_start is accepted at the earliest in the cycle after DONE, once the state is back in IDLE.
- Asserting RST mid-operation immediately returns to IDLE with reset values. No v_done is produced.
- All pulse outputs are exactly one cycle wide.

## Structure
- Shared package rv32v_hazard_pkg holds:
  - the vissue_state_t enum (IDLE, DRAIN, BUSY, DONE, FLUSH);
  - the VLMAX and TIMEOUT defaults.
- Sub-module rv32v_retire_counter: a VL_W down-counter with load, dec and clear inputs, a zero flag and a saturating floor at 0. It is instantiated once for elem_remaining.
- The watchdog is inline in the controller.

## Test plan
- Reset with v_start held high: all outputs stay 0 while RST is high, and v_busy is 0.
- vl=4, scalar stages idle, retires every cycle from BUSY entry: v_done is asserted 6 cycles after v_start, and elem_remaining steps 4,3,2,1,0.
- vl=3, busy_mem high for 5 cycles after v_start: v_busy is high for all 5 DRAIN cycles plus 3 BUSY cycles, and stall_front is asserted throughout, including the v_start cycle.
- vsetvli with vl=0: v_done, v_decode_done and csr_update pulse together 2 cycles after v_start, and there are no BUSY cycles.
- vl=8, exception_v asserted after 2 retires, coincident with a third retire: the next state is FLUSH, flush_front is high for 1 cycle, elem_remaining is 0, and there is no v_done.
- TIMEOUT=16, vl=2, no retires: v_timeout sets after 15 BUSY cycles, FLUSH follows, and v_timeout stays high through subsequent instructions until RST.
